// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory stage.
package dmem_pkg;

   // Load/store size and sign encodings (Instr[14:12]).
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Register offsets inside the MMIO window.
   localparam logic [15:0] OFF_GPIO   = 16'h0000;
   localparam logic [15:0] OFF_CYC_LO = 16'h0004;
   localparam logic [15:0] OFF_CYC_HI = 16'h0008;

   // Byte-lane write enables for a store of the given size at the given lane.
   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'b0000;
      case (f3)
         F3_B:    be = 4'b0001 << lane;
         F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
         F3_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide RAM with per-byte write enables and an asynchronous read port.
module dmem_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Combinational read returns the contents before any write at this edge.
   assign rdata = mem[addr];

   // Byte-masked write at the rising edge.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory stage: byte-masked stores, combinational extending loads.
// Define DMEM_MMIO_EN to add the MMIO window (GPIO_OUT register and 64-bit cycle counter).
module data_mem_unit
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [31:0] Addr,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        misaligned,
   output logic [31:0] gpio_out
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [1:0]    lane;
   logic [AW-1:0] word_idx;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic          wr_en;
   logic          mmio_sel;
   logic [31:0]   mmio_rdata;
   logic [31:0]   ram_rdata;
   logic [31:0]   rd_word;

   assign lane     = Addr[1:0];
   assign word_idx = Addr[AW+1:2];
   assign be       = byte_en(funct3, lane);

   // Store qualification: misaligned and reset cycles never write.
   always_comb begin
      misaligned = MemWrite & (((funct3 == F3_H) & Addr[0]) | ((funct3 == F3_W) & (|lane)));
      wr_en      = MemWrite & ~Reset & ~misaligned;
   end

   // Replicate narrow store data across lanes; the enables pick the target.
   always_comb begin
      wdata = WriteData;
      case (funct3)
         F3_B:    wdata = {4{WriteData[7:0]}};
         F3_H:    wdata = {2{WriteData[15:0]}};
         default: wdata = WriteData;
      endcase
   end

   dmem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en & ~mmio_sel),
      .be    (be),
      .addr  (word_idx),
      .wdata (wdata),
      .rdata (ram_rdata)
   );

`ifdef DMEM_MMIO_EN
   logic [31:0] gpio_q;
   logic [63:0] cycle_q;
   logic [15:0] offset;

   assign mmio_sel = (Addr[31:16] == MMIO_BASE[31:16]);
   assign offset   = {Addr[15:2], 2'b00};
   assign gpio_out = gpio_q;

   // Register read mux; unmapped offsets read as zero.
   always_comb begin
      mmio_rdata = 32'h0;
      case (offset)
         OFF_GPIO:   mmio_rdata = gpio_q;
         OFF_CYC_LO: mmio_rdata = cycle_q[31:0];
         OFF_CYC_HI: mmio_rdata = cycle_q[63:32];
         default:    mmio_rdata = 32'h0;
      endcase
   end

   // GPIO_OUT follows the same byte-lane rules as RAM.
   always_ff @(posedge clk) begin
      if (Reset) begin
         gpio_q <= 32'h0;
      end else if (wr_en && mmio_sel && (offset == OFF_GPIO)) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) gpio_q[i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // Free-running cycle counter, wraps naturally at 2^64.
   always_ff @(posedge clk) begin
      if (Reset) cycle_q <= 64'h0;
      else       cycle_q <= cycle_q + 64'h1;
   end
`else
   logic unused_cfg;

   assign mmio_sel   = 1'b0;
   assign mmio_rdata = 32'h0;
   assign gpio_out   = 32'h0;
   // Upper address bits only alias in this build.
   assign unused_cfg = ^{Addr[31:AW+2], MMIO_BASE};
`endif

   assign rd_word = mmio_sel ? mmio_rdata : ram_rdata;

   // Load extraction and extension; misaligned or reserved loads return zero.
   always_comb begin
      logic [7:0]  ld_byte;
      logic [15:0] ld_half;
      ld_byte  = rd_word[7:0];
      case (lane)
         2'd0: ld_byte = rd_word[7:0];
         2'd1: ld_byte = rd_word[15:8];
         2'd2: ld_byte = rd_word[23:16];
         2'd3: ld_byte = rd_word[31:24];
         default: ld_byte = rd_word[7:0];
      endcase
      ld_half  = Addr[1] ? rd_word[31:16] : rd_word[15:0];
      ReadData = 32'h0;
      case (funct3)
         F3_B:  ReadData = {{24{ld_byte[7]}}, ld_byte};
         F3_BU: ReadData = {24'h0, ld_byte};
         F3_H:  ReadData = Addr[0] ? 32'h0 : {{16{ld_half[15]}}, ld_half};
         F3_HU: ReadData = Addr[0] ? 32'h0 : {16'h0, ld_half};
         F3_W:  ReadData = (|lane) ? 32'h0 : rd_word;
         default: ReadData = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit (default DEPTH and MMIO_BASE).
// The MMIO sequence runs only when DMEM_MMIO_EN is defined.
module tb_data_mem_unit;

   localparam int unsigned DEPTH     = 256;
   localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        Reset;
   logic [31:0] Addr;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        misaligned;
   logic [31:0] gpio_out;

   int checks = 0;
   int errors = 0;

   data_mem_unit #(
      .DEPTH     (DEPTH),
      .MMIO_BASE (MMIO_BASE)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .Addr       (Addr),
      .MemWrite   (MemWrite),
      .funct3     (funct3),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .misaligned (misaligned),
      .gpio_out   (gpio_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] addr;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_mis;
      logic [31:0] exp_gpio;
   } vec_t;

   typedef struct {
      string       name;
      logic        chk_rd;
      logic [31:0] rd;
      logic        mis;
      logic [31:0] gpio;
   } exp_t;

   exp_t sb[$];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, push the expectation, then
   // sample the combinational outputs and retire the expectation.
   task automatic step(input vec_t v);
      exp_t e;
      @(negedge clk);
      Reset     = v.rst;
      Addr      = v.addr;
      MemWrite  = v.we;
      funct3    = v.f3;
      WriteData = v.wdata;
      sb.push_back('{v.name, v.chk_rd, v.exp_rd, v.exp_mis, v.exp_gpio});
      #2;
      e = sb.pop_front();
      if (e.chk_rd) check32({e.name, ".ReadData"}, ReadData, e.rd);
      check32({e.name, ".misaligned"}, {31'h0, misaligned}, {31'h0, e.mis});
      check32({e.name, ".gpio_out"}, gpio_out, e.gpio);
   endtask

   function automatic vec_t mk(input string name, input logic rst, input logic [31:0] addr,
                               input logic we, input logic [2:0] f3, input logic [31:0] wd,
                               input logic chk, input logic [31:0] rd, input logic mis,
                               input logic [31:0] gp);
      vec_t v;
      v = '{name, rst, addr, we, f3, wd, chk, rd, mis, gp};
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      Reset = 1'b1; Addr = 32'h0; MemWrite = 1'b0; funct3 = 3'b010; WriteData = 32'h0;
      repeat (2) @(posedge clk);

      // name, rst, addr, we, f3, wdata, chk_rd, exp_rd, exp_mis, exp_gpio
      tbl.push_back(mk("sw_beef",     0, 32'h10, 1, 3'b010, 32'hDEADBEEF, 0, 0, 0, 0));
      tbl.push_back(mk("lw_10",       0, 32'h10, 0, 3'b010, 0, 1, 32'hDEADBEEF, 0, 0));
      tbl.push_back(mk("lb_13",       0, 32'h13, 0, 3'b000, 0, 1, 32'hFFFFFFDE, 0, 0));
      tbl.push_back(mk("lbu_13",      0, 32'h13, 0, 3'b100, 0, 1, 32'h000000DE, 0, 0));
      tbl.push_back(mk("lb_10",       0, 32'h10, 0, 3'b000, 0, 1, 32'hFFFFFFEF, 0, 0));
      tbl.push_back(mk("sw_20",       0, 32'h20, 1, 3'b010, 32'h11223344, 0, 0, 0, 0));
      tbl.push_back(mk("sh_22",       0, 32'h22, 1, 3'b001, 32'h00008001, 1, 32'h00001122, 0, 0));
      tbl.push_back(mk("lw_20",       0, 32'h20, 0, 3'b010, 0, 1, 32'h80013344, 0, 0));
      tbl.push_back(mk("lh_22",       0, 32'h22, 0, 3'b001, 0, 1, 32'hFFFF8001, 0, 0));
      tbl.push_back(mk("lhu_22",      0, 32'h22, 0, 3'b101, 0, 1, 32'h00008001, 0, 0));
      tbl.push_back(mk("sw_40",       0, 32'h40, 1, 3'b010, 32'h55667788, 0, 0, 0, 0));
      tbl.push_back(mk("sw_41_mis",   0, 32'h41, 1, 3'b010, 32'h12345678, 1, 32'h0, 1, 0));
      tbl.push_back(mk("lw_40_a",     0, 32'h40, 0, 3'b010, 0, 1, 32'h55667788, 0, 0));
      tbl.push_back(mk("lw_42_mis",   0, 32'h42, 0, 3'b010, 0, 1, 32'h0, 0, 0));
      tbl.push_back(mk("sh_41_mis",   0, 32'h41, 1, 3'b001, 32'h0000FFFF, 1, 32'h0, 1, 0));
      tbl.push_back(mk("lw_40_b",     0, 32'h40, 0, 3'b010, 0, 1, 32'h55667788, 0, 0));
      tbl.push_back(mk("sb_41",       0, 32'h41, 1, 3'b000, 32'h000000AB, 1, 32'h00000077, 0, 0));
      tbl.push_back(mk("lw_40_c",     0, 32'h40, 0, 3'b010, 0, 1, 32'h5566AB88, 0, 0));
      tbl.push_back(mk("rsv_ld_40",   0, 32'h40, 0, 3'b011, 0, 1, 32'h0, 0, 0));
      tbl.push_back(mk("rsv_st_40",   0, 32'h40, 1, 3'b011, 32'h0, 1, 32'h0, 0, 0));
      tbl.push_back(mk("lw_40_d",     0, 32'h40, 0, 3'b010, 0, 1, 32'h5566AB88, 0, 0));
      tbl.push_back(mk("lh_41_ld",    0, 32'h41, 0, 3'b001, 0, 1, 32'h0, 0, 0));
      tbl.push_back(mk("sw_4",        0, 32'h04, 1, 3'b010, 32'h0BADC0DE, 0, 0, 0, 0));
      tbl.push_back(mk("sw_0",        0, 32'h00, 1, 3'b010, 32'h0, 0, 0, 0, 0));
      tbl.push_back(mk("sw_0_rst",    1, 32'h00, 1, 3'b010, 32'hCAFEF00D, 1, 32'h0, 0, 0));
      tbl.push_back(mk("lw_0_a",      0, 32'h00, 0, 3'b010, 0, 1, 32'h0, 0, 0));
      tbl.push_back(mk("sw_alias",    0, DEPTH * 4, 1, 3'b010, 32'hCAFEF00D, 1, 32'h0, 0, 0));
      tbl.push_back(mk("lw_0_b",      0, 32'h00, 0, 3'b010, 0, 1, 32'hCAFEF00D, 0, 0));
      tbl.push_back(mk("sw_10_rbw",   0, 32'h10, 1, 3'b010, 32'h12345678, 1, 32'hDEADBEEF, 0, 0));
      tbl.push_back(mk("lw_10_b",     0, 32'h10, 0, 3'b010, 0, 1, 32'h12345678, 0, 0));
      tbl.push_back(mk("lhu_10",      0, 32'h10, 0, 3'b101, 0, 1, 32'h00005678, 0, 0));
      tbl.push_back(mk("lb_12",       0, 32'h12, 0, 3'b000, 0, 1, 32'h00000034, 0, 0));
      tbl.push_back(mk("lw_4",        0, 32'h04, 0, 3'b010, 0, 1, 32'h0BADC0DE, 0, 0));

      foreach (tbl[i]) step(tbl[i]);

`ifdef DMEM_MMIO_EN
      begin
         logic [31:0] cyc_lo = MMIO_BASE + 32'h4;
         logic [31:0] cyc_hi = MMIO_BASE + 32'h8;
         logic [31:0] gpio_a = MMIO_BASE;
         logic [31:0] unmap  = MMIO_BASE + 32'hC;
         step(mk("mm_rst",     1, 32'h10, 0, 3'b010, 0, 0, 0, 0, 0));
         // k = edges since reset release; counter reads k
         step(mk("cyc_first",  0, cyc_lo, 0, 3'b010, 0, 1, 32'd0, 0, 0));
         for (int k = 1; k < 10; k++) step(mk("idle", 0, 32'h10, 0, 3'b010, 0, 0, 0, 0, 0));
         step(mk("cyc_10",     0, cyc_lo, 0, 3'b010, 0, 1, 32'd10, 0, 0));
         step(mk("sb_gpio",    0, gpio_a + 1, 1, 3'b000, 32'h000000A5, 1, 32'h0, 0, 0));
         step(mk("lw_gpio",    0, gpio_a, 0, 3'b010, 0, 1, 32'h0000A500, 0, 32'h0000A500));
         step(mk("sw_cyc",     0, cyc_lo, 1, 3'b010, 32'h0, 1, 32'd13, 0, 32'h0000A500));
         step(mk("cyc_14",     0, cyc_lo, 0, 3'b010, 0, 1, 32'd14, 0, 32'h0000A500));
         step(mk("unmapped",   0, unmap, 0, 3'b010, 0, 1, 32'h0, 0, 32'h0000A500));
         step(mk("cyc_hi",     0, cyc_hi, 0, 3'b010, 0, 1, 32'h0, 0, 32'h0000A500));
         step(mk("ram_w1",     0, 32'h04, 0, 3'b010, 0, 1, 32'h0BADC0DE, 0, 32'h0000A500));
         step(mk("ram_w0",     0, 32'h00, 0, 3'b010, 0, 1, 32'hCAFEF00D, 0, 32'h0000A500));
         step(mk("gpio_rst",   1, 32'h10, 0, 3'b010, 0, 0, 0, 0, 32'h0000A500));
         step(mk("gpio_clr",   0, cyc_lo, 0, 3'b010, 0, 1, 32'd0, 0, 32'h0));
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
